// File: rtl/cg_phase_sequencer.sv
// Phase/address sequencer for the CG solver: MATVEC -> ALPHA -> UPD_XR -> BETA -> UPD_P per iteration.
// All outputs registered; rd_ready=0 holds read address/enable, wr_valid writes land one cycle later.
module cg_phase_sequencer #(
    parameter int NO_OF_UNITS = 8,
    parameter int ADDR_W      = 32,
    parameter int ITER_W      = 11
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [31:0]       i_total,
    input  logic [ITER_W-1:0] i_max_iter,
    input  logic              i_rd_ready,
    input  logic              i_wr_valid,
    input  logic              i_scalar_valid,
    input  logic              i_converged,
    output logic [2:0]        o_phase,
    output logic [ADDR_W-1:0] o_a_rd_addr,
    output logic              o_a_rd_en,
    output logic [ADDR_W-1:0] o_vec_rd_addr,
    output logic [3:0]        o_vec_rd_en,
    output logic [ADDR_W-1:0] o_vec_wr_addr,
    output logic [3:0]        o_vec_we,
    output logic [ITER_W-1:0] o_iteration,
    output logic              o_busy,
    output logic              o_halt,
    output logic              o_err
);
    localparam int LOG2_UNITS = $clog2(NO_OF_UNITS);
    localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ITER_W-1:0] ONE_I = {{(ITER_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        PH_IDLE   = 3'd0,
        PH_MATVEC = 3'd1,
        PH_ALPHA  = 3'd2,
        PH_UPD_XR = 3'd3,
        PH_BETA   = 3'd4,
        PH_UPD_P  = 3'd5,
        PH_DONE   = 3'd6
    } phase_t;

    // Vector enable bit order is {Ap, X, R, P}
    function automatic logic [3:0] f_rd_mask(input phase_t p);
        case (p)
            PH_MATVEC: f_rd_mask = 4'b0001;
            PH_ALPHA:  f_rd_mask = 4'b1001;
            PH_UPD_XR: f_rd_mask = 4'b1111;
            PH_BETA:   f_rd_mask = 4'b0010;
            PH_UPD_P:  f_rd_mask = 4'b0011;
            default:   f_rd_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] f_wr_mask(input phase_t p);
        case (p)
            PH_MATVEC: f_wr_mask = 4'b1000;
            PH_UPD_XR: f_wr_mask = 4'b0110;
            PH_UPD_P:  f_wr_mask = 4'b0001;
            default:   f_wr_mask = 4'b0000;
        endcase
    endfunction

    phase_t              r_phase, w_phase, w_enter_ph;
    logic [ADDR_W-1:0]   r_rows, w_rows;
    logic [ITER_W-1:0]   r_max_iter, w_max_iter;
    logic [ADDR_W-1:0]   r_rd_cnt, w_rd_cnt;
    logic [ADDR_W-1:0]   r_wr_cnt, w_wr_cnt;
    logic [ADDR_W-1:0]   r_a_rd_addr, w_a_rd_addr;
    logic [ADDR_W-1:0]   r_vec_rd_addr, w_vec_rd_addr;
    logic [ADDR_W-1:0]   r_vec_wr_addr, w_vec_wr_addr;
    logic                r_a_rd_en, w_a_rd_en;
    logic [3:0]          r_vec_rd_en, w_vec_rd_en;
    logic [3:0]          r_vec_we, w_vec_we;
    logic [ITER_W-1:0]   r_iteration, w_iteration;
    logic                r_busy, w_busy;
    logic                r_halt, w_halt;
    logic                r_err, w_err;

    logic [ADDR_W-1:0]   w_new_rows;
    logic [ADDR_W-1:0]   w_rows_sq;
    logic [ADDR_W-1:0]   w_rd_total;
    logic [ITER_W-1:0]   w_iter_inc;
    logic                w_beat, w_enter, w_rd_fin, w_wr_fin;

    assign w_new_rows = ADDR_W'(i_total >> LOG2_UNITS);
    assign w_rows_sq  = r_rows * r_rows;
    assign w_rd_total = (r_phase == PH_MATVEC) ? w_rows_sq : r_rows;
    assign w_iter_inc = r_iteration + ONE_I;

    always_comb begin
        w_phase       = r_phase;
        w_rows        = r_rows;
        w_max_iter    = r_max_iter;
        w_rd_cnt      = r_rd_cnt;
        w_wr_cnt      = r_wr_cnt;
        w_a_rd_addr   = r_a_rd_addr;
        w_vec_rd_addr = r_vec_rd_addr;
        w_vec_wr_addr = r_vec_wr_addr;
        w_a_rd_en     = r_a_rd_en;
        w_vec_rd_en   = r_vec_rd_en;
        w_vec_we      = 4'b0000;
        w_iteration   = r_iteration;
        w_halt        = r_halt;
        w_err         = r_err;
        w_enter       = 1'b0;
        w_enter_ph    = r_phase;
        w_rd_fin      = 1'b0;
        w_wr_fin      = 1'b0;
        w_beat        = (r_a_rd_en | (|r_vec_rd_en)) & i_rd_ready;

        if (i_abort) begin
            w_enter    = 1'b1;
            w_enter_ph = PH_IDLE;
        end else if (i_start && (r_phase == PH_IDLE || r_phase == PH_DONE)) begin
            w_rows      = w_new_rows;
            w_max_iter  = i_max_iter;
            w_iteration = '0;
            w_halt      = 1'b0;
            w_err       = 1'b0;
            w_enter     = 1'b1;
            if (w_new_rows == '0 || i_max_iter == '0) begin
                w_enter_ph = PH_DONE;
                w_halt     = 1'b1;
                w_err      = (w_new_rows == '0);
            end else begin
                w_enter_ph = PH_MATVEC;
            end
        end else begin
            if (w_beat) begin
                w_rd_cnt = r_rd_cnt + ONE_A;
                if (r_phase == PH_MATVEC) begin
                    w_a_rd_addr   = r_a_rd_addr + ONE_A;
                    w_vec_rd_addr = (r_vec_rd_addr == r_rows - ONE_A) ? '0 : r_vec_rd_addr + ONE_A;
                end else begin
                    w_vec_rd_addr = r_vec_rd_addr + ONE_A;
                end
                if (w_rd_cnt == w_rd_total) begin
                    w_a_rd_en   = 1'b0;
                    w_vec_rd_en = 4'b0000;
                end
            end
            // Writes beyond rows, or in a phase with no write target, are dropped and flagged
            if (i_wr_valid) begin
                if (f_wr_mask(r_phase) != 4'b0000 && r_wr_cnt != r_rows) begin
                    w_vec_we      = f_wr_mask(r_phase);
                    w_vec_wr_addr = r_wr_cnt;
                    w_wr_cnt      = r_wr_cnt + ONE_A;
                end else begin
                    w_err = 1'b1;
                end
            end
            w_rd_fin = (w_rd_cnt == w_rd_total);
            w_wr_fin = (w_wr_cnt == r_rows);

            case (r_phase)
                PH_MATVEC: if (w_rd_fin && w_wr_fin) begin
                    w_enter    = 1'b1;
                    w_enter_ph = PH_ALPHA;
                end
                PH_ALPHA: if (i_scalar_valid) begin
                    w_enter    = 1'b1;
                    w_enter_ph = PH_UPD_XR;
                end
                PH_UPD_XR: if (w_rd_fin && w_wr_fin) begin
                    w_enter    = 1'b1;
                    w_enter_ph = PH_BETA;
                end
                PH_BETA: if (i_scalar_valid) begin
                    w_enter = 1'b1;
                    if (i_converged) begin
                        w_iteration = w_iter_inc;
                        w_halt      = 1'b1;
                        w_enter_ph  = PH_DONE;
                    end else begin
                        w_enter_ph  = PH_UPD_P;
                    end
                end
                PH_UPD_P: if (w_rd_fin && w_wr_fin) begin
                    w_enter     = 1'b1;
                    w_iteration = w_iter_inc;
                    if (w_iter_inc == r_max_iter) begin
                        w_enter_ph = PH_DONE;
                        w_halt     = 1'b1;
                    end else begin
                        w_enter_ph = PH_MATVEC;
                    end
                end
                default: ;
            endcase
        end

        // vec_wr_addr is left alone so the final write of the old phase keeps its address
        if (w_enter) begin
            w_phase       = w_enter_ph;
            w_rd_cnt      = '0;
            w_wr_cnt      = '0;
            w_a_rd_addr   = '0;
            w_vec_rd_addr = '0;
            w_a_rd_en     = (w_enter_ph == PH_MATVEC);
            w_vec_rd_en   = f_rd_mask(w_enter_ph);
        end
        w_busy = (w_phase != PH_IDLE) && (w_phase != PH_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_phase       <= PH_IDLE;
            r_rows        <= '0;
            r_max_iter    <= '0;
            r_rd_cnt      <= '0;
            r_wr_cnt      <= '0;
            r_a_rd_addr   <= '0;
            r_vec_rd_addr <= '0;
            r_vec_wr_addr <= '0;
            r_a_rd_en     <= 1'b0;
            r_vec_rd_en   <= 4'b0000;
            r_vec_we      <= 4'b0000;
            r_iteration   <= '0;
            r_busy        <= 1'b0;
            r_halt        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_phase       <= w_phase;
            r_rows        <= w_rows;
            r_max_iter    <= w_max_iter;
            r_rd_cnt      <= w_rd_cnt;
            r_wr_cnt      <= w_wr_cnt;
            r_a_rd_addr   <= w_a_rd_addr;
            r_vec_rd_addr <= w_vec_rd_addr;
            r_vec_wr_addr <= w_vec_wr_addr;
            r_a_rd_en     <= w_a_rd_en;
            r_vec_rd_en   <= w_vec_rd_en;
            r_vec_we      <= w_vec_we;
            r_iteration   <= w_iteration;
            r_busy        <= w_busy;
            r_halt        <= w_halt;
            r_err         <= w_err;
        end
    end

    assign o_phase       = r_phase;
    assign o_a_rd_addr   = r_a_rd_addr;
    assign o_a_rd_en     = r_a_rd_en;
    assign o_vec_rd_addr = r_vec_rd_addr;
    assign o_vec_rd_en   = r_vec_rd_en;
    assign o_vec_wr_addr = r_vec_wr_addr;
    assign o_vec_we      = r_vec_we;
    assign o_iteration   = r_iteration;
    assign o_busy        = r_busy;
    assign o_halt        = r_halt;
    assign o_err         = r_err;
endmodule

// File: tb/tb_cg_phase_sequencer.sv
// Directed bench for cg_phase_sequencer with NO_OF_UNITS=8, total=32 (rows=4).
module tb_cg_phase_sequencer;
    localparam int AW = 32;
    localparam int IW = 11;

    logic          clk;
    logic          i_reset, i_start, i_abort, i_rd_ready, i_wr_valid, i_scalar_valid, i_converged;
    logic [31:0]   i_total;
    logic [IW-1:0] i_max_iter;
    logic [2:0]    o_phase;
    logic [AW-1:0] o_a_rd_addr, o_vec_rd_addr, o_vec_wr_addr;
    logic          o_a_rd_en, o_busy, o_halt, o_err;
    logic [3:0]    o_vec_rd_en, o_vec_we;
    logic [IW-1:0] o_iteration;

    int n_assert = 0;
    int n_fail   = 0;
    logic [3:0]    wr_mask_log [0:63];
    logic [AW-1:0] wr_addr_log [0:63];
    int wr_n = 0;

    cg_phase_sequencer #(.NO_OF_UNITS(8), .ADDR_W(AW), .ITER_W(IW)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_abort(i_abort),
        .i_total(i_total), .i_max_iter(i_max_iter), .i_rd_ready(i_rd_ready),
        .i_wr_valid(i_wr_valid), .i_scalar_valid(i_scalar_valid), .i_converged(i_converged),
        .o_phase(o_phase), .o_a_rd_addr(o_a_rd_addr), .o_a_rd_en(o_a_rd_en),
        .o_vec_rd_addr(o_vec_rd_addr), .o_vec_rd_en(o_vec_rd_en),
        .o_vec_wr_addr(o_vec_wr_addr), .o_vec_we(o_vec_we), .o_iteration(o_iteration),
        .o_busy(o_busy), .o_halt(o_halt), .o_err(o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (o_vec_we != 4'b0000 && wr_n < 64) begin
            wr_mask_log[wr_n] = o_vec_we;
            wr_addr_log[wr_n] = o_vec_wr_addr;
            wr_n++;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_phase"}, o_phase, 0);
        chk({tag, "_a_addr"}, o_a_rd_addr, 0);
        chk({tag, "_v_addr"}, o_vec_rd_addr, 0);
        chk({tag, "_w_addr"}, o_vec_wr_addr, 0);
        chk({tag, "_a_en"}, o_a_rd_en, 0);
        chk({tag, "_v_en"}, o_vec_rd_en, 0);
        chk({tag, "_we"}, o_vec_we, 0);
        chk({tag, "_iter"}, o_iteration, 0);
        chk({tag, "_halt"}, o_halt, 0);
        chk({tag, "_err"}, o_err, 0);
        chk({tag, "_busy"}, o_busy, 0);
    endtask

    task automatic expect_writes(input string tag, input logic [3:0] mask);
        chk({tag, "_nwr"}, wr_n, 4);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_wmask"}, wr_mask_log[i], mask);
            chk({tag, "_waddr"}, wr_addr_log[i], i);
        end
        wr_n = 0;
    endtask

    task automatic do_start(input logic [31:0] t, input logic [IW-1:0] m);
        i_total = t;
        i_max_iter = m;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    // extra=1 drives a fifth wr_valid on the last read beat; it must be dropped
    task automatic matvec(input bit extra);
        chk("mv_phase", o_phase, 1);
        for (int k = 0; k < 16; k++) begin
            chk("mv_a_addr", o_a_rd_addr, k);
            chk("mv_p_addr", o_vec_rd_addr, k % 4);
            chk("mv_a_en", o_a_rd_en, 1);
            chk("mv_v_en", o_vec_rd_en, 4'b0001);
            i_wr_valid = extra ? (k == 4 || k == 8 || k == 12 || k == 14 || k == 15)
                               : (k >= 4 && k % 4 == 0);
            tick();
        end
        i_wr_valid = 1'b0;
        if (extra) begin
            chk("ov_phase", o_phase, 2);
            chk("ov_we", o_vec_we, 0);
            chk("ov_err", o_err, 1);
        end else begin
            chk("mv_a_en_off", o_a_rd_en, 0);
            chk("mv_hold", o_phase, 1);
            i_wr_valid = 1'b1;
            tick();
            i_wr_valid = 1'b0;
            chk("mv_exit", o_phase, 2);
        end
        expect_writes("mv", 4'b1000);
    endtask

    // Four read beats; write phases answer each beat with wr_valid one cycle later,
    // reduction phases end with scalar_valid after an idle cycle.
    task automatic rd_phase(input string tag, input logic [2:0] ph, input logic [3:0] rmask,
                            input bit writes, input bit stall, input bit conv);
        int k;
        int cyc;
        bit prev;
        k = 0;
        cyc = 0;
        prev = 1'b0;
        chk({tag, "_phase"}, o_phase, ph);
        while (k < 4) begin
            i_rd_ready = stall ? (cyc % 2 == 0) : 1'b1;
            i_wr_valid = writes & prev;
            chk({tag, "_addr"}, o_vec_rd_addr, k);
            chk({tag, "_en"}, o_vec_rd_en, rmask);
            tick();
            prev = i_rd_ready;
            if (i_rd_ready) k++;
            cyc++;
        end
        i_rd_ready = 1'b1;
        i_wr_valid = 1'b0;
        chk({tag, "_en_off"}, o_vec_rd_en, 0);
        if (writes) begin
            i_wr_valid = 1'b1;
            tick();
            i_wr_valid = 1'b0;
        end else begin
            tick();
            i_scalar_valid = 1'b1;
            i_converged = conv;
            tick();
            i_scalar_valid = 1'b0;
            i_converged = 1'b0;
        end
    endtask

    task automatic one_iter(input int it);
        matvec(1'b0);
        rd_phase("al", 3'd2, 4'b1001, 1'b0, 1'b0, 1'b0);
        rd_phase("xr", 3'd3, 4'b1111, 1'b1, 1'b0, 1'b0);
        expect_writes("xr", 4'b0110);
        rd_phase("be", 3'd4, 4'b0010, 1'b0, 1'b0, 1'b0);
        rd_phase("up", 3'd5, 4'b0011, 1'b1, 1'b0, 1'b0);
        expect_writes("up", 4'b0001);
        chk("it_count", o_iteration, it + 1);
    endtask

    initial begin
        i_reset = 1'b1;
        i_start = 1'b0;
        i_abort = 1'b0;
        i_rd_ready = 1'b1;
        i_wr_valid = 1'b0;
        i_scalar_valid = 1'b0;
        i_converged = 1'b0;
        i_total = 32'd0;
        i_max_iter = '0;
        tick();
        tick();
        chk_reset("rst");
        i_reset = 1'b0;
        tick();
        chk_reset("idle");

        // Full two-iteration solve without convergence
        do_start(32'd32, 11'd2);
        chk("st_busy", o_busy, 1);
        chk("st_iter", o_iteration, 0);
        for (int it = 0; it < 2; it++) one_iter(it);
        chk("t1_phase", o_phase, 6);
        chk("t1_halt", o_halt, 1);
        chk("t1_busy", o_busy, 0);
        chk("t1_err", o_err, 0);
        chk("t1_v_en", o_vec_rd_en, 0);

        // Early convergence, with rd_ready stalls during UPD_XR
        do_start(32'd32, 11'd2);
        chk("t2_halt_clr", o_halt, 0);
        chk("t2_iter_clr", o_iteration, 0);
        matvec(1'b0);
        rd_phase("al2", 3'd2, 4'b1001, 1'b0, 1'b0, 1'b0);
        rd_phase("xrs", 3'd3, 4'b1111, 1'b1, 1'b1, 1'b0);
        expect_writes("xrs", 4'b0110);
        rd_phase("bec", 3'd4, 4'b0010, 1'b0, 1'b0, 1'b1);
        chk("t2_phase", o_phase, 6);
        chk("t2_iter", o_iteration, 1);
        chk("t2_halt", o_halt, 1);
        chk("t2_busy", o_busy, 0);

        // Zero-length and zero-iteration solves
        do_start(32'd5, 11'd2);
        chk("z_phase", o_phase, 6);
        chk("z_halt", o_halt, 1);
        chk("z_err", o_err, 1);
        for (int i = 0; i < 3; i++) begin
            chk("z_a_en", o_a_rd_en, 0);
            chk("z_v_en", o_vec_rd_en, 0);
            chk("z_we", o_vec_we, 0);
            tick();
        end
        do_start(32'd32, 11'd0);
        chk("m0_phase", o_phase, 6);
        chk("m0_halt", o_halt, 1);
        chk("m0_err", o_err, 0);

        // Surplus write in MATVEC, single-iteration solve
        wr_n = 0;
        do_start(32'd32, 11'd1);
        matvec(1'b1);
        rd_phase("al3", 3'd2, 4'b1001, 1'b0, 1'b0, 1'b0);
        rd_phase("xr3", 3'd3, 4'b1111, 1'b1, 1'b0, 1'b0);
        expect_writes("xr3", 4'b0110);
        rd_phase("be3", 3'd4, 4'b0010, 1'b0, 1'b0, 1'b0);
        rd_phase("up3", 3'd5, 4'b0011, 1'b1, 1'b0, 1'b0);
        expect_writes("up3", 4'b0001);
        chk("t5_phase", o_phase, 6);
        chk("t5_iter", o_iteration, 1);
        chk("t5_halt", o_halt, 1);
        chk("t5_err", o_err, 1);

        // Abort in the second UPD_XR, busy start ignored, restart, then reset in BETA
        do_start(32'd32, 11'd2);
        chk("t6_err_clr", o_err, 0);
        one_iter(0);
        matvec(1'b0);
        rd_phase("al4", 3'd2, 4'b1001, 1'b0, 1'b0, 1'b0);
        chk("ab_phase_in", o_phase, 3);
        tick();
        i_rd_ready = 1'b0;
        i_start = 1'b1;
        i_scalar_valid = 1'b1;
        tick();
        i_start = 1'b0;
        i_scalar_valid = 1'b0;
        chk("busy_start_phase", o_phase, 3);
        chk("busy_start_addr", o_vec_rd_addr, 1);
        chk("busy_start_en", o_vec_rd_en, 4'b1111);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        i_rd_ready = 1'b1;
        chk("ab_phase", o_phase, 0);
        chk("ab_a_en", o_a_rd_en, 0);
        chk("ab_v_en", o_vec_rd_en, 0);
        chk("ab_we", o_vec_we, 0);
        chk("ab_iter", o_iteration, 1);
        chk("ab_busy", o_busy, 0);
        wr_n = 0;
        do_start(32'd32, 11'd2);
        chk("rs_phase", o_phase, 1);
        chk("rs_iter", o_iteration, 0);
        chk("rs_a_addr", o_a_rd_addr, 0);
        chk("rs_a_en", o_a_rd_en, 1);
        one_iter(0);
        matvec(1'b0);
        rd_phase("al5", 3'd2, 4'b1001, 1'b0, 1'b0, 1'b0);
        rd_phase("xr5", 3'd3, 4'b1111, 1'b1, 1'b0, 1'b0);
        expect_writes("xr5", 4'b0110);
        chk("be_in", o_phase, 4);
        tick();
        tick();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        chk_reset("mid_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/cg_phase_sequencer.md
# cg_phase_sequencer

Parametrised address and phase sequencer for the conjugate-gradient solver datapath. It replaces free-running per-memory address counters with an explicit phase state machine. Each iteration is stepped through the matrix-vector product, the alpha reduction, the X/R update, the beta reduction and the P update. Read and write addresses are generated for the A matrix memory and the vector memories (P, R, X, Ap), for a runtime vector length and a runtime iteration limit. It sits between the top-level start/halt logic and the NO_OF_UNITS-lane ALU.

## Interface
- NO_OF_UNITS, 8, lanes per memory word; power of 2, ≥2.
- ADDR_W, 32, width of every address output.
- ITER_W, 11, width of iteration counter and max_iter.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  pulse; begins a solve from IDLE or DONE.
- abort  in  1  synchronous; returns to IDLE.
- total  in  32  vector length in elements, sampled on accepted start.
- max_iter  in  ITER_W  iteration limit, sampled on accepted start.
- rd_ready  in  1  datapath accepts a read beat this cycle.
- wr_valid  in  1  datapath presents one result word this cycle.
- scalar_valid  in  1  pulse; reduction result (alpha/beta) is ready.
- converged  in  1  qualified by scalar_valid in BETA.
- phase  out  3  IDLE=0, MATVEC=1, ALPHA=2, UPD_XR=3, BETA=4, UPD_P=5, DONE=6.
- a_rd_addr  out  ADDR_W  A memory read address.
- a_rd_en  out  1  A read request.
- vec_rd_addr  out  ADDR_W  shared vector read address.
- vec_rd_en  out  4  read enables {Ap,X,R,P}, bit 0 = P.
- vec_wr_addr  out  ADDR_W  shared vector write address.
- vec_we  out  4  write enables {Ap,X,R,P}.
- iteration  out  ITER_W  completed iterations.
- busy  out  1  phase ∉ {IDLE, DONE}.
- halt  out  1  level; solve finished.
- err  out  1  sticky; zero-length solve or write overflow.

## Operation
- rows = total >> log2(NO_OF_UNITS); the remainder is discarded. rows and max_iter are registered on an accepted start.
- An accepted start, in IDLE or DONE, clears iteration, halt and err, then enters MATVEC.
- If rows==0 or max_iter==0 at start, the block goes to DONE with halt=1; err=1 only for rows==0.
- Read phases: rd_cnt counts from 0 to the phase read count. A read beat is an enable high with rd_ready=1. The address increments the cycle after each beat. The enable drops when rd_cnt reaches the count.
- MATVEC:
  - A is read for rows·rows words; a_rd_addr runs 0..rows²−1.
  - vec_rd_en=P, with vec_rd_addr = beat index mod rows, wrapping to 0 after rows−1.
  - wr_valid writes Ap at vec_wr_addr 0..rows−1.
  - Exit when rows writes are done and rows² reads are done.
- ALPHA: reads P and Ap for 0..rows−1. Exit on scalar_valid, even if reads are incomplete; remaining reads are abandoned.
- UPD_XR:
  - Reads X, R, P and Ap for 0..rows−1.
  - Each wr_valid asserts vec_we = X|R at vec_wr_addr.
  - Exit when rows reads and rows writes are done.
- BETA: reads R for 0..rows−1. On scalar_valid:
  - if converged=1, increment iteration, set halt and go to DONE;
  - otherwise go to UPD_P.
- UPD_P: reads P and R. wr_valid writes P. Exit on rows reads and rows writes; then iteration+1, and:
  - if iteration+1 == max_iter, go to DONE with halt=1;
  - otherwise go to MATVEC.
- wr_valid with wr_cnt==rows, or in ALPHA/BETA/IDLE/DONE, is dropped (vec_we stays 0) and sets err.
- scalar_valid outside ALPHA/BETA is ignored. start while busy is ignored.
- abort takes priority over every condition except reset. It goes to IDLE and zeros the enables; iteration, halt and err are held.

## Timing
- Reset values:
  - phase=IDLE;
  - all addresses 0, all enables 0;
  - iteration=0, halt=0, err=0, busy=0.
- All outputs are registered. Priority is reset > abort > start > phase logic.
- Phase entry: on the cycle after the exit condition, the new phase is presented with all address counters at 0 and the read enables asserted.
- Read enable and address are valid in the same cycle. A stall (rd_ready=0) holds both.
- vec_we is asserted in the cycle after wr_valid, with vec_wr_addr equal to the pre-increment count.
- Exit condition met in cycle N: the last vec_we is in cycle N+1, and the new phase is visible in cycle N+1.
- halt rises in the same cycle as phase=DONE.
- Address arithmetic is modulo 2^ADDR_W; rows² wraps silently.

## Test plan
- NO_OF_UNITS=8, total=32 (rows=4), max_iter=2, rd_ready=1, wr_valid one cycle after each read, scalar_valid 2 cycles after the reads end, converged=0 → a_rd_addr 0..15; P address 0,1,2,3 repeated 4 times; full phase order twice; iteration=2; halt=1 in DONE.
- Same setup, with converged=1 on the first BETA scalar_valid → UPD_P skipped; iteration=1; halt=1.
- Toggle rd_ready 1,0,1,0 during UPD_XR → each address is held while stalled; exactly 4 X|R writes at addresses 0..3.
- total=5 with start → DONE next cycle; halt=1; err=1; no enables ever asserted.
- 5th wr_valid in MATVEC with rows=4 → no vec_we; err=1; phase sequencing unaffected.
- abort mid UPD_XR, then start → IDLE with enables 0, then MATVEC with iteration=0 and addresses 0. reset mid BETA → all reset values the next cycle.
